// File: rtl/choice_pkg.sv
// rtl/choice_pkg.sv - shared types, constants and counter update rule for the choice update path
package choice_pkg;

    localparam int HIST_W = 12;
    localparam int CTR_W  = 3;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [CTR_W-1:0] CTR_MAX  = 3'd7;
    localparam logic [CTR_W-1:0] CTR_INIT = 3'b100;

    typedef struct packed {
        logic [HIST_W-1:0] hist;
        logic              lp;
        logic              gp;
    } choice_entry_t;

    typedef struct packed {
        logic              valid;
        logic [HIST_W-1:0] hist;
        logic              lp_ok;
        logic              gp_ok;
    } choice_upd_t;

    // Move toward whichever component alone was right; saturate at both ends.
    function automatic logic [CTR_W-1:0] choice_next(input logic [CTR_W-1:0] old_ctr,
                                                    input logic             lp_ok,
                                                    input logic             gp_ok);
        logic [CTR_W-1:0] nxt;
        nxt = old_ctr;
        if (gp_ok && !lp_ok && old_ctr != CTR_MAX) begin
            nxt = old_ctr + 1'b1;
        end else if (lp_ok && !gp_ok && old_ctr != '0) begin
            nxt = old_ctr - 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/choice_update_fifo.sv
// rtl/choice_update_fifo.sv - in-order queue of outstanding predictions with flush and occupancy count
module choice_update_fifo
    import choice_pkg::*;
#(
    parameter int DEPTH_P = DEPTH,
    parameter int CNT_W_P = $clog2(DEPTH_P + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               push_i,
    input  choice_entry_t      push_data_i,
    input  logic               pop_i,
    output choice_entry_t      pop_data_o,
    output logic [CNT_W_P-1:0] count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = $clog2(DEPTH_P);

    choice_entry_t      mem_q [DEPTH_P];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W_P-1:0] count_q;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CNT_W_P'(DEPTH_P));
    assign empty_o = (count_q == '0);

    // Flush masks both ends so a same-cycle push or pop is dropped.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (do_pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CNT_W_P'(do_push) - CNT_W_P'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/choice_update_unit.sv
// rtl/choice_update_unit.sv - queues predictions and read-modify-writes the choice counter on resolution
module choice_update_unit
    import choice_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pred_valid_i,
    output logic              pred_ready_o,
    input  logic [HIST_W-1:0] pred_hist_i,
    input  logic              pred_lp_i,
    input  logic              pred_gp_i,
    input  logic              res_valid_i,
    output logic              res_ready_o,
    input  logic              res_taken_i,
    input  logic              flush_i,
    output logic [HIST_W-1:0] tbl_rd_addr_o,
    input  logic [CTR_W-1:0]  tbl_rd_data_i,
    output logic              tbl_wr_en_o,
    output logic [HIST_W-1:0] tbl_wr_addr_o,
    output logic [CTR_W-1:0]  tbl_wr_data_o,
    output logic [CNT_W-1:0]  count_o
);

    choice_entry_t     push_entry, head_entry;
    logic              fifo_full, fifo_empty, pop_fire;

    choice_upd_t       r_q, r_d;
    logic              w_valid_q, w_valid_d;
    logic [HIST_W-1:0] w_hist_q, w_hist_d;
    logic [CTR_W-1:0]  w_data_q, w_data_d;
    logic [CTR_W-1:0]  old_ctr, new_ctr;

    assign push_entry = '{hist: pred_hist_i, lp: pred_lp_i, gp: pred_gp_i};

    choice_update_fifo #(.DEPTH_P(DEPTH), .CNT_W_P(CNT_W)) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (pred_valid_i),
        .push_data_i (push_entry),
        .pop_i       (res_valid_i),
        .pop_data_o  (head_entry),
        .count_o     (count_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign pred_ready_o = !fifo_full && !flush_i;
    assign res_ready_o  = !fifo_empty && !flush_i;
    assign pop_fire     = res_valid_i && res_ready_o;

    // A write still sitting in W has not reached the table yet, so it overrides the read.
    assign tbl_rd_addr_o = r_q.hist;
    assign old_ctr = (w_valid_q && (w_hist_q == r_q.hist)) ? w_data_q : tbl_rd_data_i;
    assign new_ctr = choice_next(old_ctr, r_q.lp_ok, r_q.gp_ok);

    always_comb begin
        r_d       = r_q;
        r_d.valid = pop_fire;
        if (pop_fire) begin
            r_d.hist  = head_entry.hist;
            r_d.lp_ok = (head_entry.lp == res_taken_i);
            r_d.gp_ok = (head_entry.gp == res_taken_i);
        end

        w_valid_d = r_q.valid && (new_ctr != old_ctr);
        w_hist_d  = w_hist_q;
        w_data_d  = w_data_q;
        if (r_q.valid) begin
            w_hist_d = r_q.hist;
            w_data_d = new_ctr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q       <= '0;
            w_valid_q <= 1'b0;
            w_hist_q  <= '0;
            w_data_q  <= '0;
        end else begin
            r_q       <= r_d;
            w_valid_q <= w_valid_d;
            w_hist_q  <= w_hist_d;
            w_data_q  <= w_data_d;
        end
    end

    assign tbl_wr_en_o   = w_valid_q;
    assign tbl_wr_addr_o = w_hist_q;
    assign tbl_wr_data_o = w_data_q;

endmodule
